axis_frame_gen: RTL
===================

Name: axis_frame_gen

Overview:
AXI4-Stream video frame transmitter. It is the source-side counterpart of the frame-completion monitor. It emits frames of img_vsize lines × img_hsize pixels with a deterministic ramp pattern. Start-of-frame is marked on tuser and end-of-line on tlast, per the video AXIS convention used throughout the IMG datapath. It feeds IMG pipelines and benches that need a known-good stream, and raises a one-cycle frame-done interrupt after the last beat is accepted.

Parameters:
DATA_W, 24, tdata width in bits
HSIZE_W, 12, width of pixel-per-line count and x counter
VSIZE_W, 12, width of line count and y counter

Ports:
m_axis_aclk  in  1  clock
m_axis_aresetn  in  1  synchronous active-low reset
start  in  1  single-cycle pulse; begin a frame when idle
continuous  in  1  1 = start the next frame automatically after the current one
img_hsize  in  HSIZE_W  pixels per line, latched at frame start
img_vsize  in  VSIZE_W  lines per frame, latched at frame start
blank_cycles  in  8  idle cycles between lines (used only with FRMGEN_HBLANK_EN)
m_axis_tdata  out  DATA_W  pixel value
m_axis_tvalid  out  1  beat valid
m_axis_tready  in  1  sink ready
m_axis_tlast  out  1  last pixel of line
m_axis_tuser  out  1  first pixel of frame
busy  out  1  frame in progress
frm_done_irq  out  1  one-cycle pulse at frame completion

Behaviour:
- Interface: one clock, m_axis_aclk. Reset m_axis_aresetn is synchronous, active-low.
- Reset values: tvalid, tlast, tuser, busy and frm_done_irq = 0; tdata = 0; x = 0; y = 0; state = IDLE.
- Reset mid-frame: all outputs return to reset values at the next edge; the frame is abandoned, and no irq is raised.
- State IDLE:
  - On start=1 with img_hsize≠0 and img_vsize≠0: latch both sizes, set x=y=0, go to ACTIVE.
  - tvalid asserts in the cycle after start (latency 1).
  - start with either size = 0 is ignored.
  - start while not IDLE is ignored.
- State ACTIVE:
  - tvalid=1 and busy=1.
  - tdata = zero-extended (x + y) modulo 2^DATA_W. Sum width is max(HSIZE_W,VSIZE_W)+1, truncated or extended to DATA_W.
  - tuser=1 only when x=0 and y=0.
  - tlast=1 only when x = hsize_l−1.
  - A beat transfers when tvalid & tready.
  - While tready=0, tdata, tlast and tuser hold stable and tvalid stays 1 (AXIS rule).
- On each transfer:
  - If x < hsize_l−1: x increments.
  - Otherwise (end of line): x=0, and:
    - if y < vsize_l−1: y increments, and the next state is HBLANK when enabled with blank_cycles≠0, else ACTIVE;
    - otherwise the frame ends and the next state is DONE.
- State HBLANK (macro only):
  - tvalid=0, busy=1.
  - A down-counter loaded with the latched blank_cycles runs; return to ACTIVE when it reaches 0.
  - Gap length = blank_cycles cycles exactly.
- State DONE: lasts one cycle with frm_done_irq=1 and tvalid=0.
  - If continuous=1: re-latch sizes (zero sizes → IDLE), reset x and y, go to ACTIVE. The next tuser beat is then valid 2 cycles after the final tlast transfer.
  - Else go to IDLE; busy drops in the cycle after DONE.
- Deasserting continuous mid-frame: the current frame completes normally, then the block goes to IDLE.
- Size inputs changing mid-frame have no effect until the next latch.
- hsize_l=1: every beat has tlast=1.
- Frame 1×1: one beat with tuser=tlast=1.
- Counters never wrap within a frame, because sizes are latched and compared with ==.

Optional Feature:
- Macro: FRMGEN_HBLANK_EN.
- Defined: HBLANK state and the 8-bit gap counter are built. blank_cycles is latched at frame start, and that many tvalid=0 cycles are inserted after every line except the last line of the frame.
- Undefined: no HBLANK state, blank_cycles is ignored, and lines are back-to-back with no tvalid gap when tready stays high.

Test Plan:
1. hsize=4, vsize=3, tready=1, continuous=0, start pulse → 12 beats on consecutive cycles; tdata 0,1,2,3,1,2,3,4,2,3,4,5; tuser on beat 1 only; tlast on beats 4, 8 and 12; one frm_done_irq pulse 1 cycle after beat 12; busy low afterwards.
2. Same frame with tready toggling 1,0,0,1 repeatedly → identical beat sequence; outputs stable during stalls; tvalid never drops mid-line.
3. continuous=1, hsize=2, vsize=2 → frames repeat with tuser every 4 beats and irq after each frame; clear continuous during frame 2 → exactly 2 frames, then IDLE.
4. FRMGEN_HBLANK_EN defined, blank_cycles=3, hsize=2, vsize=3, tready=1 → 3 tvalid-low cycles after lines 1 and 2 only; total frame 6 beats + 6 gap cycles.
5. Pulse m_axis_aresetn low at beat 5 of test 1 → tvalid=0 next edge and no irq; a fresh start afterwards restarts with tuser and tdata=0.
6. start with vsize=0 → no tvalid and busy stays 0; then hsize=1, vsize=1 → a single beat with tuser=tlast=1, tdata=0, followed by an irq.

Source files
------------

// File: rtl/axis_frame_gen_if.sv
// rtl/axis_frame_gen_if.sv - AXI4-Stream video bundle (tdata/tvalid/tready/tlast/tuser)
interface axis_frame_gen_if #(
  parameter int DATA_W = 24
) ();

  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic              tuser;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    output tuser,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    input  tuser,
    output tready
  );

endinterface

// File: rtl/axis_frame_gen.sv
// rtl/axis_frame_gen.sv - AXI4-Stream ramp-pattern video frame source with frame-done irq
// Optional inter-line blanking gap built when FRMGEN_HBLANK_EN is defined.
module axis_frame_gen #(
  parameter int DATA_W  = 24,
  parameter int HSIZE_W = 12,
  parameter int VSIZE_W = 12
) (
  input  logic               m_axis_aclk,
  input  logic               m_axis_aresetn,
  input  logic               start,
  input  logic               continuous,
  input  logic [HSIZE_W-1:0] img_hsize,
  input  logic [VSIZE_W-1:0] img_vsize,
  input  logic [7:0]         blank_cycles,
  axis_frame_gen_if.master   m_axis,
  output logic               busy,
  output logic               frm_done_irq
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd3;
`ifdef FRMGEN_HBLANK_EN
  localparam logic [1:0] ST_HBLANK = 2'd2;
`endif

  localparam int SUM_W = ((HSIZE_W > VSIZE_W) ? HSIZE_W : VSIZE_W) + 1;

  logic [1:0]         r_state;
  logic [HSIZE_W-1:0] r_x;
  logic [VSIZE_W-1:0] r_y;
  logic [HSIZE_W-1:0] r_hsize_l;
  logic [VSIZE_W-1:0] r_vsize_l;
`ifdef FRMGEN_HBLANK_EN
  logic [7:0]         r_blank_l;
  logic [7:0]         r_blank_cnt;
`else
  logic               w_unused_blank;
  assign w_unused_blank = ^blank_cycles;
`endif

  logic               w_active;
  logic               w_beat;
  logic               w_x_last;
  logic               w_y_last;
  logic               w_sizes_ok;
  logic [SUM_W-1:0]   w_sum;

  assign w_active   = (r_state == ST_ACTIVE);
  assign w_beat     = w_active && m_axis.tready;
  assign w_x_last   = (r_x == (r_hsize_l - HSIZE_W'(1)));
  assign w_y_last   = (r_y == (r_vsize_l - VSIZE_W'(1)));
  assign w_sizes_ok = (img_hsize != '0) && (img_vsize != '0);
  assign w_sum      = SUM_W'(r_x) + SUM_W'(r_y);

  // Outputs decode straight from registered state, so reset clears them at the next edge.
  assign m_axis.tvalid = w_active;
  assign m_axis.tdata  = w_active ? DATA_W'(w_sum) : '0;
  assign m_axis.tlast  = w_active && w_x_last;
  assign m_axis.tuser  = w_active && (r_x == '0) && (r_y == '0);
  assign busy          = (r_state != ST_IDLE);
  assign frm_done_irq  = (r_state == ST_DONE);

  always_ff @(posedge m_axis_aclk) begin
    if (!m_axis_aresetn) begin
      r_state     <= ST_IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_hsize_l   <= '0;
      r_vsize_l   <= '0;
`ifdef FRMGEN_HBLANK_EN
      r_blank_l   <= '0;
      r_blank_cnt <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start && w_sizes_ok) begin
            r_hsize_l <= img_hsize;
            r_vsize_l <= img_vsize;
`ifdef FRMGEN_HBLANK_EN
            r_blank_l <= blank_cycles;
`endif
            r_x       <= '0;
            r_y       <= '0;
            r_state   <= ST_ACTIVE;
          end
        end

        ST_ACTIVE: begin
          if (w_beat) begin
            if (!w_x_last) begin
              r_x <= r_x + HSIZE_W'(1);
            end else begin
              r_x <= '0;
              if (!w_y_last) begin
                r_y <= r_y + VSIZE_W'(1);
`ifdef FRMGEN_HBLANK_EN
                // Counter is preloaded one short so HBLANK lasts exactly r_blank_l cycles.
                if (r_blank_l != 8'd0) begin
                  r_blank_cnt <= r_blank_l - 8'd1;
                  r_state     <= ST_HBLANK;
                end
`endif
              end else begin
                r_state <= ST_DONE;
              end
            end
          end
        end

`ifdef FRMGEN_HBLANK_EN
        ST_HBLANK: begin
          if (r_blank_cnt == 8'd0) begin
            r_state <= ST_ACTIVE;
          end else begin
            r_blank_cnt <= r_blank_cnt - 8'd1;
          end
        end
`endif

        ST_DONE: begin
          if (continuous && w_sizes_ok) begin
            r_hsize_l <= img_hsize;
            r_vsize_l <= img_vsize;
`ifdef FRMGEN_HBLANK_EN
            r_blank_l <= blank_cycles;
`endif
            r_x       <= '0;
            r_y       <= '0;
            r_state   <= ST_ACTIVE;
          end else begin
            r_state <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
